// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and transmitter state encoding
package uart_pkg;
    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 234;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO, wrap-bit pointers distinguish full from empty
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = CW'(wr_ptr - rd_ptr);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // pointer advance; the extra top bit toggles on each wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
    // storage array, no reset needed since contents are gated by the pointers
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_byte_transmitter.sv
// uart_byte_transmitter: FIFO-buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for 8E1
module uart_byte_transmitter import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [7:0]                          tx_data,
    input  logic                                tx_valid,
    output logic                                tx_ready,
    output logic                                uart_tx,
    output logic                                busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);
    localparam int BW = $clog2(CLKS_PER_BIT);
`ifdef UART_TX_PARITY_EN
    localparam uart_tx_state_t AFTER_DATA = PARITY;
`else
    localparam uart_tx_state_t AFTER_DATA = STOP;
`endif
    uart_tx_state_t state, state_n;
    logic [BW-1:0]  baud;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift, fifo_dout;
    logic           full, empty, push, pop, tick, last_bit, line;
    assign tx_ready = !full;
    assign push     = tx_valid && !full;
    assign tick     = baud == BW'(CLKS_PER_BIT-1);
    assign last_bit = bit_cnt == 3'(UART_DATA_BITS-1);
    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );
`ifdef UART_TX_PARITY_EN
    logic par_q;
    assign line = state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par_q : 1'b1;
    // even parity of the byte, captured when it leaves the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else if (pop) par_q <= ^fifo_dout;
    end
`else
    assign line = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
`endif
    // frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end
    // next state and FIFO pop; STOP pops directly into START for gapless frames
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                pop     = !empty;
                state_n = empty ? IDLE : START;
            end
            START:  state_n = tick ? DATA : START;
            DATA:   state_n = (tick && last_bit) ? AFTER_DATA : DATA;
            PARITY: state_n = tick ? STOP : PARITY;
            STOP: begin
                pop     = tick && !empty;
                state_n = !tick ? STOP : empty ? IDLE : START;
            end
            default: state_n = IDLE;
        endcase
    end
    // baud/bit counters, shift register and registered line/busy outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
            busy    <= 1'b0;
        end else begin
            baud    <= (state == IDLE || tick) ? '0 : baud + 1'b1;
            bit_cnt <= pop ? '0 : (state == DATA && tick) ? bit_cnt + 1'b1 : bit_cnt;
            shift   <= pop ? fifo_dout : (state == DATA && tick) ? shift >> 1 : shift;
            uart_tx <= line;
            busy    <= state != IDLE || !empty || push;
        end
    end
endmodule

// File: tb/tb_uart_byte_transmitter.sv
// tb_uart_byte_transmitter: scoreboard bench decoding the serial line against queued bytes
module tb_uart_byte_transmitter;
    localparam int CPB = 4;
    localparam int DEP = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, uart_tx, busy;
    logic [2:0] fifo_count;

    uart_byte_transmitter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         contig = 0;
    logic [7:0] sb[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_frame(input logic [NB-1:0] b);
        logic [7:0] exp;
        chk("start_bit", int'(b[0]), 0);
        chk("stop_bit", int'(b[NB-1]), 1);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got %02h expected no frame", b[8:1]);
        end else begin
            exp = sb.pop_front();
            chk("data", int'(b[8:1]), int'(exp));
`ifdef UART_TX_PARITY_EN
            chk("parity", int'(b[9]), int'(^exp));
`endif
        end
    endtask

    // line monitor: decode each frame, check every bit lasts exactly CPB cycles
    int          mcnt = 0;
    int          ncyc = 0;
    int          prev_end = -10;
    bit          in_frame = 1'b0;
    logic [NB-1:0] bits;
    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) in_frame = 1'b0;
        else begin
            if (!in_frame && uart_tx == 1'b0) begin
                in_frame = 1'b1;
                mcnt = 0;
                if (ncyc == prev_end + 1) contig++;
            end
            if (in_frame) begin
                if (mcnt % CPB == 0) bits[mcnt/CPB] = uart_tx;
                else chk("bit_width", int'(uart_tx), int'(bits[mcnt/CPB]));
                mcnt++;
                if (mcnt == FL) begin
                    in_frame = 1'b0;
                    prev_end = ncyc;
                    check_frame(bits);
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        bit ok = 1'b0;
        tx_valid = 1'b1;
        tx_data = b;
        for (int t = 0; t < 1000 && !ok; t++) begin
            ok = tx_ready;
            if (ok) sb.push_back(b);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", int'(sb.size() == 0 && !busy), 1);
    endtask

    initial begin
        int c0, accepted, rdy_low;
        logic [7:0] hb[6];
        repeat (3) @(negedge clk);
        chk("rst_tx", int'(uart_tx), 1);
        chk("rst_ready", int'(tx_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(fifo_count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        push_byte(8'h55);
        chk("count_after_push", int'(fifo_count), 1);
        chk("busy_after_push", int'(busy), 1);
        chk("tx_idle_n0", int'(uart_tx), 1);
        @(negedge clk);
        chk("tx_idle_n1", int'(uart_tx), 1);
        chk("count_after_pop", int'(fifo_count), 0);
        @(negedge clk);
        chk("tx_start_n2", int'(uart_tx), 0);
        repeat (FL - 1) @(negedge clk);
        chk("tx_last_stop", int'(uart_tx), 1);
        chk("busy_last_stop", int'(busy), 1);
        @(negedge clk);
        chk("busy_drop", int'(busy), 0);
        chk("single_frame_seen", sb.size(), 0);

        c0 = contig;
        push_byte(8'hA3);
        push_byte(8'h0F);
        push_byte(8'hFF);
        wait_drain();
        chk("contiguous_frames", contig - c0, 2);

        foreach (hb[i]) hb[i] = 8'($urandom);
        accepted = 0;
        rdy_low = 0;
        tx_valid = 1'b1;
        for (int t = 0; t < 2000 && accepted < 6; t++) begin
            tx_data = hb[accepted];
            chk("ready_vs_full", int'(tx_ready), int'(fifo_count != 3'(DEP)));
            if (!tx_ready) rdy_low++;
            if (tx_ready) begin
                sb.push_back(hb[accepted]);
                accepted++;
            end
            @(negedge clk);
        end
        tx_valid = 1'b0;
        chk("hold_accepted", accepted, 6);
        chk("ready_low_cycles", rdy_low, FL - 3);
        wait_drain();

        push_byte(8'h81);
        repeat (19) @(negedge clk);
        chk("pre_reset_bit3", int'(uart_tx), 0);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_tx", int'(uart_tx), 1);
        chk("midrst_count", int'(fifo_count), 0);
        chk("midrst_ready", int'(tx_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_byte(8'h42);
        wait_drain();

`ifdef UART_TX_PARITY_EN
        push_byte(8'h07);
        wait_drain();
        push_byte(8'h03);
        wait_drain();
`endif

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 7) == 0) repeat (FL) @(negedge clk);
            push_byte(8'($urandom));
        end
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
